// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS control FSM (master) and the datapath (slave).
// MC_PERF_COUNT_EN adds the instr_count/stall_count performance counters.
interface multicycle_control_if;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic [2:0]  selAlu;
   logic        pc_en;
   logic [1:0]  pc_src;
   logic        iord;
   logic        mem_rd;
   logic        mem_wr;
   logic        ir_write;
   logic        reg_write;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic        illegal;
`ifdef MC_PERF_COUNT_EN
   logic [31:0] instr_count;
   logic [31:0] stall_count;
`endif

   modport master (
      input  opcode, zero, mem_ready,
      output selAlu, pc_en, pc_src, iord, mem_rd, mem_wr, ir_write, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, illegal
`ifdef MC_PERF_COUNT_EN
      , output instr_count, stall_count
`endif
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  selAlu, pc_en, pc_src, iord, mem_rd, mem_wr, ir_write, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, illegal
`ifdef MC_PERF_COUNT_EN
      , input instr_count, stall_count
`endif
   );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath (R-type, ADDI/ANDI/ORI/SLTI, LW, SW, BEQ).
// Optional MC_PERF_COUNT_EN: retired-instruction and memory-stall counters.
module multicycle_control #(
   parameter int OP_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_control_if.master bus
);
   localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
   localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
   localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
      EXEC_R, R_WB, EXEC_I, I_WB, BRANCH
   } state_t;

   state_t state, nxt;

   logic [2:0] sel_alu;
   logic       pc_en, iord, mem_rd, mem_wr, ir_write, reg_write, reg_dst, mem_to_reg;
   logic       alu_src_a, illegal;
   logic [1:0] pc_src, alu_src_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= nxt;
   end

   always_comb begin
      nxt        = FETCH;
      sel_alu    = 3'b000;
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      iord       = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      illegal    = 1'b0;
      // Outputs are forced low for the whole reset window, not just after the next edge.
      if (!rst) begin
         case (state)
            FETCH: begin
               mem_rd    = 1'b1;
               alu_src_b = 2'b01;
               sel_alu   = 3'b001;
               ir_write  = bus.mem_ready;
               pc_en     = bus.mem_ready;
               nxt       = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
               alu_src_b = 2'b11;
               sel_alu   = 3'b001;
               case (bus.opcode)
                  OP_R:                               nxt = EXEC_R;
                  OP_LW, OP_SW:                       nxt = MEM_ADDR;
                  OP_BEQ:                             nxt = BRANCH;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  nxt = EXEC_I;
                  default: begin
                     illegal = 1'b1;
                     nxt     = FETCH;
                  end
               endcase
            end
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               sel_alu   = 3'b001;
               nxt       = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
               mem_rd = 1'b1;
               iord   = 1'b1;
               nxt    = bus.mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEM_WR: begin
               mem_wr = 1'b1;
               iord   = 1'b1;
               nxt    = bus.mem_ready ? FETCH : MEM_WR;
            end
            EXEC_R: begin
               alu_src_a = 1'b1;
               nxt       = R_WB;
            end
            R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            EXEC_I: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               case (bus.opcode)
                  OP_ORI:  sel_alu = 3'b010;
                  OP_ANDI: sel_alu = 3'b011;
                  OP_SLTI: sel_alu = 3'b100;
                  default: sel_alu = 3'b001;
               endcase
               nxt = I_WB;
            end
            I_WB: reg_write = 1'b1;
            BRANCH: begin
               alu_src_a = 1'b1;
               sel_alu   = 3'b101;
               pc_src    = 2'b01;
               pc_en     = bus.zero;
            end
            default: nxt = FETCH;
         endcase
      end
   end

   assign bus.selAlu     = sel_alu;
   assign bus.pc_en      = pc_en;
   assign bus.pc_src     = pc_src;
   assign bus.iord       = iord;
   assign bus.mem_rd     = mem_rd;
   assign bus.mem_wr     = mem_wr;
   assign bus.ir_write   = ir_write;
   assign bus.reg_write  = reg_write;
   assign bus.reg_dst    = reg_dst;
   assign bus.mem_to_reg = mem_to_reg;
   assign bus.alu_src_a  = alu_src_a;
   assign bus.alu_src_b  = alu_src_b;
   assign bus.illegal    = illegal;

`ifdef MC_PERF_COUNT_EN
   logic [31:0] icnt, scnt;
   logic        retire, stall;

   // Retire on the edge that re-enters FETCH from a completed instruction; illegal decode excluded.
   assign retire = (state == MEM_WB) || (state == R_WB) || (state == I_WB) ||
                   (state == BRANCH) || ((state == MEM_WR) && bus.mem_ready);
   assign stall  = ((state == FETCH) || (state == MEM_RD) || (state == MEM_WR)) &&
                   !bus.mem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         icnt <= 32'd0;
         scnt <= 32'd0;
      end else begin
         if (retire) icnt <= icnt + 32'd1;
         if (stall)  scnt <= scnt + 32'd1;
      end
   end

   assign bus.instr_count = icnt;
   assign bus.stall_count = scnt;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction phase recipes drive mem_ready/zero
// and predict every cycle's control vector; perf counters checked when MC_PERF_COUNT_EN is set.
module tb_multicycle_control;
   localparam int P_FETCH = 0, P_DEC = 1, P_ADDR = 2, P_MRD = 3, P_MWB = 4, P_MWR = 5;
   localparam int P_EXR = 6, P_RWB = 7, P_EXI = 8, P_IWB = 9, P_BR = 10;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0, n_bad = 0;
   int   m_icnt = 0, m_scnt = 0;

   multicycle_control_if bus();
   multicycle_control #(.OP_W(6)) dut (.clk(clk), .rst(rst), .bus(bus.master));

   always #5 clk = ~clk;

   wire [16:0] obs = {bus.selAlu, bus.pc_en, bus.pc_src, bus.iord, bus.mem_rd, bus.mem_wr,
                      bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                      bus.alu_src_a, bus.alu_src_b, bus.illegal};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {RT, LW, SW, BEQ, ADDI, ANDI, ORI, SLTI};
   endfunction

   function automatic logic [5:0] pick_op(input int i);
      case (i)
         0: return RT;    1: return LW;    2: return SW;   3: return BEQ;
         4: return ADDI;  5: return ANDI;  6: return ORI;  7: return SLTI;
         8: return 6'b111111;  9: return 6'b000010;  default: return 6'b100000;
      endcase
   endfunction

   // Expected control vector for one cycle of an instruction phase.
   function automatic logic [16:0] expv(input int ph, input bit mr, input bit z, input logic [5:0] op);
      logic [2:0] sel;
      logic       pe, io, rd, wr, irw, rw, rdst, m2r, sa, ill;
      logic [1:0] ps, sb;
      {sel, pe, ps, io, rd, wr, irw, rw, rdst, m2r, sa, sb, ill} = '0;
      case (ph)
         P_FETCH: begin rd = 1; sb = 2'b01; sel = 3'd1; pe = mr; irw = mr; end
         P_DEC:   begin sb = 2'b11; sel = 3'd1; ill = !is_legal(op); end
         P_ADDR:  begin sa = 1; sb = 2'b10; sel = 3'd1; end
         P_MRD:   begin rd = 1; io = 1; end
         P_MWB:   begin rw = 1; m2r = 1; end
         P_MWR:   begin wr = 1; io = 1; end
         P_EXR:   sa = 1;
         P_RWB:   begin rw = 1; rdst = 1; end
         P_EXI: begin
            sa = 1; sb = 2'b10;
            sel = (op == ADDI) ? 3'd1 : (op == ORI) ? 3'd2 : (op == ANDI) ? 3'd3 : 3'd4;
         end
         P_IWB:   rw = 1;
         P_BR:    begin sa = 1; sel = 3'd5; ps = 2'b01; pe = z; end
         default: ;
      endcase
      return {sel, pe, ps, io, rd, wr, irw, rw, rdst, m2r, sa, sb, ill};
   endfunction

   // Called #1 after a rising edge; drives this cycle's inputs, checks mid-cycle, moves to next edge.
   task automatic do_step(input string tag, input int ph, input bit mr, input bit z, input logic [5:0] op);
      bus.opcode    = op;
      bus.mem_ready = mr;
      bus.zero      = z;
      @(negedge clk);
      chk(tag, 32'(obs), 32'(expv(ph, mr, z, op)));
      if ((ph == P_FETCH || ph == P_MRD || ph == P_MWR) && !mr) m_scnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_perf(input string tag);
`ifdef MC_PERF_COUNT_EN
      chk({tag, "_icnt"}, bus.instr_count, 32'(m_icnt));
      chk({tag, "_scnt"}, bus.stall_count, 32'(m_scnt));
`endif
   endtask

   task automatic run_instr(input string tag, input logic [5:0] op, input bit z, input int wf, input int wm);
      bit r;
      for (int i = 0; i < wf; i++) do_step({tag, "_fwait"}, P_FETCH, 1'b0, 1'($urandom), op);
      do_step({tag, "_fetch"}, P_FETCH, 1'b1, 1'($urandom), op);
      r = 1'($urandom);
      do_step({tag, "_dec"}, P_DEC, r, 1'($urandom), op);
      case (op)
         LW: begin
            do_step({tag, "_addr"}, P_ADDR, 1'($urandom), 1'($urandom), op);
            for (int i = 0; i < wm; i++) do_step({tag, "_mrdw"}, P_MRD, 1'b0, 1'($urandom), op);
            do_step({tag, "_mrd"}, P_MRD, 1'b1, 1'($urandom), op);
            do_step({tag, "_mwb"}, P_MWB, 1'($urandom), 1'($urandom), op);
         end
         SW: begin
            do_step({tag, "_addr"}, P_ADDR, 1'($urandom), 1'($urandom), op);
            for (int i = 0; i < wm; i++) do_step({tag, "_mwrw"}, P_MWR, 1'b0, 1'($urandom), op);
            do_step({tag, "_mwr"}, P_MWR, 1'b1, 1'($urandom), op);
         end
         RT: begin
            do_step({tag, "_exr"}, P_EXR, 1'($urandom), 1'($urandom), op);
            do_step({tag, "_rwb"}, P_RWB, 1'($urandom), 1'($urandom), op);
         end
         BEQ: do_step({tag, "_br"}, P_BR, 1'($urandom), z, op);
         ADDI, ANDI, ORI, SLTI: begin
            do_step({tag, "_exi"}, P_EXI, 1'($urandom), 1'($urandom), op);
            do_step({tag, "_iwb"}, P_IWB, 1'($urandom), 1'($urandom), op);
         end
         default: ;
      endcase
      if (is_legal(op)) m_icnt++;
      chk_perf(tag);
   endtask

   initial begin
      rst = 1'b1;
      bus.opcode = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_idle", 32'(obs), 32'd0);
      chk_perf("rst_idle");
      rst = 1'b0;

      // LW into MEM_RD, then reset lands while the read is stalled.
      do_step("pre_fwait", P_FETCH, 1'b0, 1'b0, LW);
      do_step("pre_fetch", P_FETCH, 1'b1, 1'b0, LW);
      do_step("pre_dec",   P_DEC,   1'b1, 1'b0, LW);
      do_step("pre_addr",  P_ADDR,  1'b1, 1'b0, LW);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("pre_mrd", 32'(obs), 32'(expv(P_MRD, 1'b0, 1'b0, LW)));
      #1 rst = 1'b1;
      #1 chk("rst_mid", 32'(obs), 32'd0);
      m_icnt = 0; m_scnt = 0;
      chk_perf("rst_mid");
      @(posedge clk);
      #1 chk("rst_hold", 32'(obs), 32'd0);
      rst = 1'b0;

      run_instr("add",   RT,   1'b0, 0, 0);
      run_instr("lw",    LW,   1'b0, 0, 2);
      run_instr("beq_t", BEQ,  1'b1, 0, 0);
      run_instr("beq_f", BEQ,  1'b0, 0, 0);
      run_instr("addi",  ADDI, 1'b0, 0, 0);
      run_instr("ori",   ORI,  1'b0, 0, 0);
      run_instr("andi",  ANDI, 1'b0, 0, 0);
      run_instr("slti",  SLTI, 1'b0, 0, 0);
      run_instr("ill",   6'b111111, 1'b0, 0, 0);
      run_instr("sw",    SW,   1'b0, 1, 1);

      for (int k = 0; k < 300; k++)
         run_instr("rnd", pick_op($urandom_range(0, 10)), 1'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2));
      do_step("final_fetch", P_FETCH, 1'b0, 1'b0, RT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
